// File: rtl/serial_out_pkg.sv
// Shared types and line levels for the serial_out datapath controller.
package serial_out_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load shift register with a single serial bit output.
// MSB_FIRST selects both the presented bit and the shift direction.
module piso_shreg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             r,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic             sbit
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (r) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift_en) begin
      q <= MSB_FIRST ? (q << 1) : (q >> 1);
    end
  end

  assign sbit = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/serial_out_ctrl.sv
// Frames a parallel word as start/data/stop bits on sout, each bit DIV clocks.
// Optional even-parity bit between data and stop: define SERIAL_OUT_PARITY_EN.
module serial_out_ctrl
  import serial_out_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             r,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             bit_tick,
  output logic             busy,
  output logic             done
);

  localparam int BCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int NCW = $clog2(WIDTH) + 1;

  state_t           state, state_nx;
  logic [BCW-1:0]   baud;
  logic [NCW-1:0]   bitcnt;
  logic             tick;
  logic             accept;
  logic             last_bit;
  logic             shift_bit;

  assign accept   = din_valid && (state == IDLE);
  assign tick     = (state != IDLE) && (baud == BCW'(DIV - 1));
  assign last_bit = (bitcnt == NCW'(WIDTH - 1));

  piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk      (clk),
    .r        (r),
    .load     (accept),
    .shift_en ((state == DATA) && tick),
    .d        (din),
    .sbit     (shift_bit)
  );

`ifdef SERIAL_OUT_PARITY_EN
  // Word is shifted out by the time PARITY runs, so capture parity at load.
  logic par;
  always_ff @(posedge clk) begin
    if (r)           par <= 1'b0;
    else if (accept) par <= ^din;
  end
`endif

  always_ff @(posedge clk) begin
    if (r) state <= IDLE;
    else   state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (r) begin
      baud   <= '0;
      bitcnt <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == STOP) && tick;
      if (state == IDLE || tick) baud <= '0;
      else                       baud <= baud + BCW'(1);
      if (state == START && tick)
        bitcnt <= '0;
      else if (state == DATA && tick && !last_bit)
        bitcnt <= bitcnt + NCW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (accept) state_nx = START;
      START:  if (tick) state_nx = DATA;
`ifdef SERIAL_OUT_PARITY_EN
      DATA:   if (tick && last_bit) state_nx = PARITY;
      PARITY: if (tick) state_nx = STOP;
`else
      DATA:   if (tick && last_bit) state_nx = STOP;
`endif
      STOP:   if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sout = IDLE_LEVEL;
    case (state)
      START:  sout = START_LEVEL;
      DATA:   sout = shift_bit;
`ifdef SERIAL_OUT_PARITY_EN
      PARITY: sout = par;
`endif
      default: sout = IDLE_LEVEL;
    endcase
    busy      = (state != IDLE);
    din_ready = (state == IDLE);
    bit_tick  = tick;
  end

endmodule
